regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 60 ++++++
 1 files changed

// File: rtl/regfile.sv
// 32 x 32-bit register file: one write port and two combinational read ports. r0 always reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] r_regs [0:31];

    logic        w_re    [2];
    logic [4:0]  w_raddr [2];

    assign w_re[0]    = re1;
    assign w_re[1]    = re2;
    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    // Registers are cleared on reset, so the array stays in flops rather than block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [31:0] w_data;

            always_comb begin
                w_data = '0;
                if (rst || !w_re[gi] || (w_raddr[gi] == 5'd0)) begin
                    w_data = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (we && (waddr != 5'd0) && (waddr == w_raddr[gi])) begin
                    w_data = wdata;
`endif
                end else begin
                    w_data = r_regs[w_raddr[gi]];
                end
            end
        end
    endgenerate

    assign rdata1 = g_rd[0].w_data;
    assign rdata2 = g_rd[1].w_data;

endmodule
